osram_reader: RTL and testbench

// Read-back end of the OSRAM write path. After the corelet raises ready, this block

---
 rtl/osram_reader_if.sv | 22 ++
 rtl/osram_reader.sv | 148 ++++++++++++++
 tb/tb_osram_reader.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/osram_reader_if.sv
// Output row stream of the OSRAM read-back path.
// Valid/ready handshake carrying one OSRAM row per transfer.
interface osram_reader_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [col*psum_bw-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/osram_reader.sv
// OSRAM read-back: streams depth rows in address order through a
// 2-entry skid FIFO with optional per-lane ReLU applied at push.
module osram_reader #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int addr_w  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   relu_en,
  input  logic [col*psum_bw-1:0] O_Q,
  output logic [addr_w-1:0]      O_A,
  output logic                   O_CEN,
  output logic                   O_WEN,
  osram_reader_if.master         out_if,
  output logic                   busy,
  output logic                   done
);

  localparam int rw = col * psum_bw;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [addr_w-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              relu_q, relu_d;
  logic [rw-1:0]     mem_q [2];
  logic [rw-1:0]     mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;

  logic          push;
  logic          pop;
  logic          issue;
  logic          credit;
  logic [rw-1:0] push_data;

  always_comb begin
    push_data = O_Q;
    if (relu_q) begin
      for (int i = 0; i < col; i++) begin
        if (O_Q[psum_bw*i+psum_bw-1]) begin
          push_data[psum_bw*i +: psum_bw] = '0;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    relu_d   = relu_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    issue    = 1'b0;
    done     = 1'b0;

    push = inflight_q;
    pop  = out_if.out_valid & out_if.out_ready;

    // Counting this cycle's pop lets a full FIFO keep streaming at rate.
    credit = ({1'b0, count_q} + {2'b0, inflight_q}
             - {2'b0, pop}) < 3'd2;

    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          addr_d  = '0;
          relu_d  = relu_en;
        end
      end
      S_READ: begin
        if (credit) begin
          issue = 1'b1;
          if (addr_q == addr_w'(depth - 1)) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + addr_w'(1);
          end
        end
      end
      S_DRAIN: begin
        if (count_d == 2'd0 && !inflight_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    inflight_d = issue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      relu_q     <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      relu_q     <= relu_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign O_CEN            = ~issue;
  assign O_WEN            = 1'b1;
  assign O_A              = addr_q;
  assign busy             = (state_q != S_IDLE);
  assign out_if.out_valid = (count_q != 2'd0);
  assign out_if.out_data  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_osram_reader.sv
// Self-checking bench for osram_reader against a row-level
// model of the OSRAM contents and the ReLU rule.
module tb_osram_reader;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int RW    = COL * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          relu_en = 1'b0;
  logic [RW-1:0] o_q = '0;
  logic [AW-1:0] o_a;
  logic          o_cen;
  logic          o_wen;
  logic          busy;
  logic          done;
  logic [RW-1:0] sram [DEPTH];

  osram_reader_if #(.col(COL), .psum_bw(BW)) out_if ();

  osram_reader #(
    .col(COL), .psum_bw(BW), .depth(DEPTH), .addr_w(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .relu_en(relu_en),
    .O_Q(o_q),
    .O_A(o_a),
    .O_CEN(o_cen),
    .O_WEN(o_wen),
    .out_if(out_if),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!o_cen) o_q <= sram[o_a];
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [RW-1:0] got[$];
  int  issue_addrs[$];
  int  done_cyc, done_cnt, first_valid;
  int  max_ahead, stall_bad, busy_bad, late_issue;
  bit  timed_out;

  function automatic logic [RW-1:0] model_row(input int a, input bit relu);
    logic [RW-1:0] r;
    int v;
    r = sram[a];
    for (int i = 0; i < COL; i++) begin
      v = int'($signed(r[i*BW +: BW]));
      if (relu && v < 0) r[i*BW +: BW] = '0;
    end
    return r;
  endfunction

  task automatic fill_linear();
    for (int a = 0; a < DEPTH; a++)
      for (int i = 0; i < COL; i++)
        sram[a][i*BW +: BW] = 16'(a * 8 + i);
  endtask

  task automatic fill_random();
    for (int a = 0; a < DEPTH; a++)
      for (int i = 0; i < COL; i++)
        sram[a][i*BW +: BW] = 16'($urandom);
  endtask

  // mode 0: ready=1; 1: stalled 3..10 then toggled; 2: random
  task automatic run(input bit relu, input int mode, input bit flip,
                     input int start2, input int stop_at,
                     input bit pre, input bit chain);
    int cyc, issued, xfer;
    bit prev_stall;
    logic [RW-1:0] prev_data;
    got.delete();
    issue_addrs.delete();
    done_cyc = -1; done_cnt = 0; first_valid = -1;
    max_ahead = 0; stall_bad = 0; busy_bad = 0; late_issue = 0;
    timed_out = 0; issued = 0; xfer = 0; prev_stall = 0;
    prev_data = '0;
    @(posedge clk); #1;
    if (!pre) begin
      start = 1'b1; relu_en = relu; cyc = 0;
    end else begin
      cyc = 1;
    end
    forever begin
      if (cyc > 0) begin
        start = (cyc == start2) ||
                (chain && done_cyc >= 0 && cyc == done_cyc + 1);
        if (flip) relu_en = ~relu_en;
      end
      case (mode)
        1: out_if.out_ready = (cyc < 3) ? 1'b1 :
                              (cyc <= 10) ? 1'b0 :
                              (((cyc - 11) % 2) == 0);
        2: out_if.out_ready = 1'($urandom_range(0, 1));
        default: out_if.out_ready = 1'b1;
      endcase
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!o_cen) begin
        issued++;
        issue_addrs.push_back(int'(o_a));
        if (done_cyc >= 0 && cyc > done_cyc) late_issue++;
      end
      if (prev_stall &&
          (!out_if.out_valid || out_if.out_data !== prev_data))
        stall_bad++;
      if (out_if.out_valid && first_valid < 0) first_valid = cyc;
      if (out_if.out_valid && out_if.out_ready) begin
        got.push_back(out_if.out_data);
        xfer++;
      end
      if (issued - xfer > max_ahead) max_ahead = issued - xfer;
      prev_stall = out_if.out_valid && !out_if.out_ready;
      prev_data  = out_if.out_data;
      if (cyc >= 1 && done_cyc < 0 && !busy) busy_bad++;
      if (done_cyc >= 0 && cyc > done_cyc && busy) busy_bad++;
      if (stop_at > 0 && cyc == stop_at) break;
      if (done_cyc >= 0 && cyc == done_cyc + (chain ? 1 : 3)) break;
      if (cyc >= 400) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    out_if.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({o_cen, o_wen, o_a, out_if.out_valid, busy, done} !== {2'b11, 4'd0, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_ctrl: cen=%b wen=%b a=%0d v=%b busy=%b done=%b want 1 1 0 0 0 0",
               o_cen, o_wen, o_a, out_if.out_valid, busy, done);
    end
    n_cmp++;
    if (out_if.out_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", out_if.out_data);
    end
  endtask

  task automatic test_full_rate();
    fill_linear();
    run(0, 0, 0, -1, 0, 0, 0);
    n_cmp++;
    if (timed_out || got.size() != DEPTH) begin
      n_bad++;
      $display("FAIL full_count: got %0d rows want %0d", got.size(), DEPTH);
    end
    for (int a = 0; a < got.size(); a++) begin
      n_cmp++;
      if (got[a] !== model_row(a, 0)) begin
        n_bad++;
        $display("FAIL full_row%0d: got %h want %h", a, got[a], model_row(a, 0));
      end
    end
    n_cmp++;
    if (first_valid != 3 || done_cyc != 19 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL full_timing: valid@%0d done@%0d x%0d want 3 19 1",
               first_valid, done_cyc, done_cnt);
    end
    n_cmp++;
    if (busy_bad != 0 || late_issue != 0) begin
      n_bad++;
      $display("FAIL full_busy: busy_bad=%0d late=%0d want 0 0", busy_bad, late_issue);
    end
    for (int a = 0; a < issue_addrs.size(); a++) begin
      n_cmp++;
      if (issue_addrs[a] != a) begin
        n_bad++;
        $display("FAIL full_addr%0d: got %0d want %0d", a, issue_addrs[a], a);
      end
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    run(0, 1, 0, -1, 0, 0, 0);
    n_cmp++;
    if (timed_out || got.size() != DEPTH) begin
      n_bad++;
      $display("FAIL bp_count: got %0d rows want %0d", got.size(), DEPTH);
    end
    for (int a = 0; a < got.size(); a++) begin
      n_cmp++;
      if (got[a] !== model_row(a, 0)) begin
        n_bad++;
        $display("FAIL bp_row%0d: got %h want %h", a, got[a], model_row(a, 0));
      end
    end
    n_cmp++;
    if (max_ahead > 2 || stall_bad != 0 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL bp_flow: ahead=%0d stall_bad=%0d done=%0d want <=2 0 1",
               max_ahead, stall_bad, done_cnt);
    end
  endtask

  task automatic test_relu();
    logic [63:0] pat;
    pat = {16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    for (int a = 0; a < DEPTH; a++)
      for (int i = 0; i < COL; i++)
        sram[a][i*BW +: BW] = pat[((i + a) % 4)*16 +: 16];
    for (int r = 1; r >= 0; r--) begin
      run(r[0], 0, 1, -1, 0, 0, 0);
      n_cmp++;
      if (timed_out || got.size() != DEPTH) begin
        n_bad++;
        $display("FAIL relu%0d_count: got %0d want %0d", r, got.size(), DEPTH);
      end
      for (int a = 0; a < got.size(); a++) begin
        n_cmp++;
        if (got[a] !== model_row(a, r[0])) begin
          n_bad++;
          $display("FAIL relu%0d_row%0d: got %h want %h",
                   r, a, got[a], model_row(a, r[0]));
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    fill_random();
    run(0, 0, 0, 5, 0, 0, 0);
    run(0, 0, 0, 19, 0, 0, 0);
    n_cmp++;
    if (timed_out || got.size() != DEPTH || done_cnt != 1 || done_cyc != 19) begin
      n_bad++;
      $display("FAIL ign_run: rows=%0d done=%0d@%0d want 16 1@19",
               got.size(), done_cnt, done_cyc);
    end
    n_cmp++;
    if (busy_bad != 0 || late_issue != 0) begin
      n_bad++;
      $display("FAIL ign_after: busy_bad=%0d late=%0d want 0 0", busy_bad, late_issue);
    end
  endtask

  task automatic test_reset_mid_run();
    fill_random();
    run(0, 0, 0, -1, 8, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_cen, o_a, out_if.out_valid, busy, done} !== {1'b1, 4'd0, 3'b000} ||
        out_if.out_data !== '0) begin
      n_bad++;
      $display("FAIL rst_mid: cen=%b a=%0d v=%b busy=%b done=%b d=%h want 1 0 0 0 0 0",
               o_cen, o_a, out_if.out_valid, busy, done, out_if.out_data);
    end
    run(0, 0, 0, -1, 0, 0, 0);
    n_cmp++;
    if (timed_out || got.size() != DEPTH || done_cyc != 19) begin
      n_bad++;
      $display("FAIL rst_rerun: rows=%0d done@%0d want 16 @19", got.size(), done_cyc);
    end
    for (int a = 0; a < got.size(); a++) begin
      n_cmp++;
      if (got[a] !== model_row(a, 0)) begin
        n_bad++;
        $display("FAIL rst_row%0d: got %h want %h", a, got[a], model_row(a, 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    for (int k = 0; k < 2; k++) begin
      run(1, 0, 0, -1, 0, k[0], k == 0);
      n_cmp++;
      if (timed_out || got.size() != DEPTH || done_cyc != 19 || done_cnt != 1) begin
        n_bad++;
        $display("FAIL b2b%0d_run: rows=%0d done=%0d@%0d want 16 1@19",
                 k, got.size(), done_cnt, done_cyc);
      end
      for (int a = 0; a < got.size(); a++) begin
        n_cmp++;
        if (got[a] !== model_row(a, 1)) begin
          n_bad++;
          $display("FAIL b2b%0d_row%0d: got %h want %h", k, a, got[a], model_row(a, 1));
        end
      end
    end
  endtask

  task automatic test_random();
    bit r;
    for (int k = 0; k < 4; k++) begin
      fill_random();
      r = 1'($urandom_range(0, 1));
      run(r, 2, 0, -1, 0, 0, 0);
      n_cmp++;
      if (timed_out || got.size() != DEPTH || done_cnt != 1) begin
        n_bad++;
        $display("FAIL rnd%0d_count: rows=%0d done=%0d want 16 1", k, got.size(), done_cnt);
      end
      n_cmp++;
      if (max_ahead > 2 || stall_bad != 0 || busy_bad != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_flow: ahead=%0d stall=%0d busy=%0d want <=2 0 0",
                 k, max_ahead, stall_bad, busy_bad);
      end
      for (int a = 0; a < got.size(); a++) begin
        n_cmp++;
        if (got[a] !== model_row(a, r)) begin
          n_bad++;
          $display("FAIL rnd%0d_row%0d: got %h want %h", k, a, got[a], model_row(a, r));
        end
      end
    end
  endtask

  initial begin
    out_if.out_ready = 1'b1;
    fill_linear();
    test_reset();
    test_full_rate();
    test_backpressure();
    test_relu();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
